// File: rtl/mem_bus_arb_pkg.sv
// mem_bus_arb_pkg: shared encodings for the memory bus arbiter.
//   - FSM state codes (IDLE / ADDR / DATA)
//   - owner codes (INST = 0, DATA = 1)
//   - sram-like transfer size codes (byte / half / word)
package mem_bus_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: transaction watchdog for mem_bus_arb.
// Only instantiated when MEM_ARB_WATCHDOG_EN is defined.
// Ports:
//   clk, resetn  clock, async active-low reset
//   start_i      grant cycle; clears the counter as the FSM enters ADDR
//   active_i     FSM is in ADDR or DATA; counter advances once per cycle
//   timeout_o    sticky flag, set when the counter reaches WDOG_CYCLES
module mem_arb_wdog #(
    parameter int WDOG_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    input  logic active_i,
    output logic timeout_o
);

    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (active_i && (cnt_q != LIMIT)) begin
            // saturate at the limit so a hung bus never wraps the count
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: two-master (instruction / data) to one sram-like slave arbiter,
// at most one outstanding bus transaction.
// Ports:
//   clk, resetn                    clock, async active-low reset
//   inst_req/inst_addr             instruction fetch request (word read)
//   inst_addr_ok/data_ok/rdata     instruction-side responses
//   data_req/wr/size/wstrb/addr/wdata  data-side request
//   data_addr_ok/data_ok/rdata     data-side responses
//   bus_*                          shared master port and slave responses
//   bus_timeout                    sticky watchdog flag
// Build option: MEM_ARB_WATCHDOG_EN adds the mem_arb_wdog watchdog; without it
// bus_timeout is tied to 0.
//
// state | meaning
// IDLE  | no transaction; grant any pending request and latch its fields
// ADDR  | bus_req driven from latched fields, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic any_req;
    logic grant_data;

    assign any_req = inst_req | data_req;
    // On a conflict the side that did not win last time gets the bus.
    assign grant_data = data_req & (~inst_req | (last_q == OWNER_INST));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wstrb_d = wstrb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ADDR;
                    owner_d = grant_data ? OWNER_DATA : OWNER_INST;
                    last_d  = grant_data ? OWNER_DATA : OWNER_INST;
                    if (grant_data) begin
                        wr_d    = data_wr;
                        size_d  = data_size;
                        wstrb_d = data_wstrb;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        size_d  = SIZE_WORD;
                        wstrb_d = 4'b0000;
                        addr_d  = inst_addr;
                        wdata_d = 32'h0;
                    end
                end
            end
            // a coincident bus_data_ok is ignored here; only DATA consumes it
            ST_ADDR: if (bus_addr_ok) state_d = ST_DATA;
            ST_DATA: if (bus_data_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_INST;
            last_q  <= OWNER_INST;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            wstrb_q <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wstrb_q <= wstrb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_req   = (state_q == ST_ADDR);
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_wstrb = wstrb_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    assign inst_addr_ok = bus_addr_ok & (state_q == ST_ADDR) & (owner_q == OWNER_INST);
    assign data_addr_ok = bus_addr_ok & (state_q == ST_ADDR) & (owner_q == OWNER_DATA);
    assign inst_data_ok = bus_data_ok & (state_q == ST_DATA) & (owner_q == OWNER_INST);
    assign data_data_ok = bus_data_ok & (state_q == ST_DATA) & (owner_q == OWNER_DATA);

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

`ifdef MEM_ARB_WATCHDOG_EN
    logic wdog_start;
    logic wdog_active;

    assign wdog_start  = (state_q == ST_IDLE) & any_req;
    assign wdog_active = (state_q != ST_IDLE);

    mem_arb_wdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (wdog_start),
        .active_i (wdog_active),
        .timeout_o(bus_timeout)
    );
`else
    // Watchdog compiled out: flag is constant 0; the parameter stays on the
    // interface so both builds instantiate identically.
    assign bus_timeout = 1'b0 & (WDOG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
module tb_mem_bus_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        bus_timeout;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arb #(.WDOG_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "bench time limit exceeded");
    end

    // {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    function automatic logic [4:0] ok_vec();
        return {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    endfunction

    function automatic logic [95:0] fields_vec();
        return {25'h0, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;
    endtask

    typedef struct {
        logic        ireq, dreq, aok, dok;
        logic [4:0]  exp_ok;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[12];

    // reference model state (transaction level)
    bit          m_busy, m_acc, m_own_data, m_last_data;
    logic [95:0] m_fields;

    initial begin
        // both masters always requesting, slave always ready:
        // grants must go D, I, D, I; bus_data_ok in ADDR must not complete early
        tbl[0]  = '{1, 1, 1, 1, 5'b00000, 32'h0};
        tbl[1]  = '{1, 1, 1, 1, 5'b10010, 32'h2000};
        tbl[2]  = '{1, 1, 1, 1, 5'b00001, 32'h2000};
        tbl[3]  = '{1, 1, 1, 1, 5'b00000, 32'h2000};
        tbl[4]  = '{1, 1, 1, 1, 5'b11000, 32'h1000};
        tbl[5]  = '{1, 1, 1, 1, 5'b00100, 32'h1000};
        tbl[6]  = '{1, 1, 1, 1, 5'b00000, 32'h1000};
        tbl[7]  = '{1, 1, 1, 1, 5'b10010, 32'h2000};
        tbl[8]  = '{1, 1, 1, 1, 5'b00001, 32'h2000};
        tbl[9]  = '{1, 1, 1, 1, 5'b00000, 32'h2000};
        tbl[10] = '{1, 1, 1, 1, 5'b11000, 32'h1000};
        tbl[11] = '{1, 1, 1, 1, 5'b00100, 32'h1000};

        // ---- reset state ----
        clear_inputs();
        resetn = 0;
        bus_addr_ok = 1; bus_data_ok = 1;
        #3;
        chk("reset_ok", {91'h0, ok_vec()}, 96'h0);
        chk("reset_fields", fields_vec(), 96'h0);
        chk("reset_timeout", {95'h0, bus_timeout}, 96'h0);
        do_reset();

        // ---- conflict table ----
        inst_addr = 32'h1000; data_addr = 32'h2000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
            bus_addr_ok = tbl[i].aok; bus_data_ok = tbl[i].dok;
            #1;
            chk($sformatf("tbl_ok[%0d]", i), {91'h0, ok_vec()}, {91'h0, tbl[i].exp_ok});
            chk($sformatf("tbl_addr[%0d]", i), {64'h0, bus_addr}, {64'h0, tbl[i].exp_addr});
        end

        // ---- instruction fetch only ----
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000;
        #1; chk("if_c0", {91'h0, ok_vec()}, 96'h0);
        @(negedge clk); inst_req = 0; inst_addr = 32'h0; #1;
        chk("if_c1_ok", {91'h0, ok_vec()}, {91'h0, 5'b10000});
        chk("if_c1_fields", fields_vec(), {25'h0, 1'b0, 2'd2, 4'b0000, 32'hBFC00000, 32'h0});
        @(negedge clk); bus_addr_ok = 1; #1;
        chk("if_c2_ok", {91'h0, ok_vec()}, {91'h0, 5'b11000});
        @(negedge clk); bus_addr_ok = 0; #1;
        chk("if_c3_ok", {91'h0, ok_vec()}, 96'h0);
        @(negedge clk); bus_data_ok = 1; bus_rdata = 32'h3C080001; #1;
        chk("if_c4_ok", {91'h0, ok_vec()}, {91'h0, 5'b00100});
        chk("if_c4_rdata", {32'h0, inst_rdata, data_rdata}, {32'h0, 32'h3C080001, 32'h3C080001});
        @(negedge clk); bus_data_ok = 0; #1;
        chk("if_c5_ok", {91'h0, ok_vec()}, 96'h0);

        // ---- data byte store ----
        do_reset();
        data_req = 1; data_wr = 1; data_size = 2'd0; data_wstrb = 4'b0100;
        data_addr = 32'h80001002; data_wdata = 32'h00AB0000;
        @(negedge clk); data_req = 0; bus_addr_ok = 1; #1;
        chk("st_addr_ok", {91'h0, ok_vec()}, {91'h0, 5'b10010});
        chk("st_fields", fields_vec(), {25'h0, 1'b1, 2'd0, 4'b0100, 32'h80001002, 32'h00AB0000});
        @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; #1;
        chk("st_data_ok", {91'h0, ok_vec()}, {91'h0, 5'b00001});
        @(negedge clk); bus_data_ok = 0;

        // ---- fields held while slave stalls ----
        do_reset();
        data_req = 1; data_wr = 0; data_addr = 32'h12345678;
        @(negedge clk); data_req = 0; data_addr = 32'h0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("hold_addr[%0d]", k), {64'h0, bus_addr}, {64'h0, 32'h12345678});
            chk($sformatf("hold_ok[%0d]", k), {91'h0, ok_vec()}, {91'h0, 5'b10000});
            @(negedge clk);
        end
        bus_addr_ok = 1; #1;
        chk("hold_accept", {91'h0, ok_vec()}, {91'h0, 5'b10010});
        @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; #1;
        chk("hold_done", {91'h0, ok_vec()}, {91'h0, 5'b00001});
        @(negedge clk); bus_data_ok = 0;

        // ---- reset in DATA abandons the transaction ----
        do_reset();
        inst_req = 1; inst_addr = 32'h00400000;
        @(negedge clk); inst_req = 0; bus_addr_ok = 1;
        @(negedge clk); bus_addr_ok = 0; #1;
        chk("rst_in_data_pre", {91'h0, ok_vec()}, 96'h0);
        resetn = 0; #2; resetn = 1;
        bus_data_ok = 1; #1;
        chk("rst_in_data_ok", {91'h0, ok_vec()}, 96'h0);
        @(negedge clk); #1;
        chk("rst_in_data_ok2", {91'h0, ok_vec()}, 96'h0);
        chk("rst_in_data_fields", fields_vec(), 96'h0);
        bus_data_ok = 0; data_req = 1; data_addr = 32'h55;
        @(negedge clk); data_req = 0; #1;
        chk("rst_in_data_idle", {91'h0, ok_vec()}, {91'h0, 5'b10000});

        // ---- watchdog ----
        do_reset();
        data_req = 1; data_addr = 32'h77;
        @(negedge clk); data_req = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); #1;
`ifdef MEM_ARB_WATCHDOG_EN
            chk($sformatf("wdog[%0d]", k), {95'h0, bus_timeout}, {95'h0, (k >= 8)});
`else
            chk($sformatf("wdog[%0d]", k), {95'h0, bus_timeout}, 96'h0);
`endif
        end
        bus_addr_ok = 1; @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1;
        @(negedge clk); bus_data_ok = 0; #1;
`ifdef MEM_ARB_WATCHDOG_EN
        chk("wdog_sticky", {95'h0, bus_timeout}, {95'h0, 1'b1});
`else
        chk("wdog_sticky", {95'h0, bus_timeout}, 96'h0);
`endif
        do_reset(); #1;
        chk("wdog_cleared", {95'h0, bus_timeout}, 96'h0);

        // ---- randomized against transaction-level model ----
        m_busy = 0; m_acc = 0; m_own_data = 0; m_last_data = 0; m_fields = '0;
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] exp_ok;
            @(negedge clk);
            inst_req    = ($urandom_range(0, 2) != 0);
            data_req    = ($urandom_range(0, 2) != 0);
            inst_addr   = $urandom;
            data_wr     = $urandom_range(0, 1);
            data_size   = 2'($urandom_range(0, 2));
            data_wstrb  = 4'($urandom);
            data_addr   = $urandom;
            data_wdata  = $urandom;
            bus_addr_ok = $urandom_range(0, 1);
            bus_data_ok = $urandom_range(0, 1);
            bus_rdata   = $urandom;
            #1;
            exp_ok[4] = m_busy && !m_acc;
            exp_ok[3] = bus_addr_ok && m_busy && !m_acc && !m_own_data;
            exp_ok[2] = bus_data_ok && m_busy && m_acc && !m_own_data;
            exp_ok[1] = bus_addr_ok && m_busy && !m_acc && m_own_data;
            exp_ok[0] = bus_data_ok && m_busy && m_acc && m_own_data;
            chk("rand_ok", {91'h0, ok_vec()}, {91'h0, exp_ok});
            chk("rand_fields", fields_vec(), m_fields);
            chk("rand_rdata", {32'h0, inst_rdata, data_rdata}, {32'h0, bus_rdata, bus_rdata});
            @(posedge clk);
            if (!m_busy) begin
                if (inst_req || data_req) begin
                    m_own_data  = data_req && (!inst_req || !m_last_data);
                    m_last_data = m_own_data;
                    m_busy = 1; m_acc = 0;
                    if (m_own_data)
                        m_fields = {25'h0, data_wr, data_size, data_wstrb, data_addr, data_wdata};
                    else
                        m_fields = {25'h0, 1'b0, 2'd2, 4'b0000, inst_addr, 32'h0};
                end
            end else if (!m_acc) begin
                if (bus_addr_ok) m_acc = 1;
            end else if (bus_data_ok) begin
                m_busy = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
